rx_escape_decoder: RTL
======================

// Module: rx_escape_decoder
// PURPOSE
//  Parametrised RX stream decoder between UART-RX and the debug TAP. Strips escape sequences,
//  tags command symbols, passes ESC,ESC through as literal data, and buffers decoded symbols
//  in a DEPTH-entry FWFT queue so the TAP can lag the UART without stalling it.
// PARAMETERS
//  WIDTH        8      symbol width in bits, >=2
//  ESC          8'hB1  escape symbol, WIDTH bits
//  DEPTH        4      decoded-symbol queue entries; power of two, >=2
//  ESC_TIMEOUT  1024   cycles an escape may stay pending (used only with RX_ESC_TIMEOUT_EN), >=2
// PORTS
//  CLK_I          in   1                   clock, rising edge
//  RST_NI         in   1                   asynchronous reset, active-low
//  DATA_REC_I     in   WIDTH               UART-RX head symbol
//  RX_EMPTY_I     in   1                   UART-RX FIFO empty
//  READ_O         out  1                   pop UART-RX (1-cycle strobe per symbol)
//  READ_I         in   1                   TAP pops the queue head
//  RX_EMPTY_O     out  1                   queue empty
//  COMMAND_O      out  1                   head symbol is a command; valid when !RX_EMPTY_O
//  DATA_REC_O     out  WIDTH               head symbol; valid when !RX_EMPTY_O
//  LEVEL_O        out  $clog2(DEPTH+1)     queue occupancy
//  ESC_TIMEOUT_O  out  1                   1-cycle pulse: pending escape abandoned
// BEHAVIOUR
//  Reset: FSM st_idle, queue cleared; READ_O=0, RX_EMPTY_O=1, COMMAND_O=0, DATA_REC_O=0,
//   LEVEL_O=0, ESC_TIMEOUT_O=0. Mid-sequence reset drops a pending escape; nothing queued.
//  Upstream: READ_O = !RX_EMPTY_I && LEVEL_O<DEPTH (combinational, same cycle); DATA_REC_I is
//   sampled on that edge. Full queue: READ_O=0 even if TAP pops that cycle (no fall-through).
//  FSM (state_t):
//   st_idle:   on read, sym==ESC -> st_escape (no push); else push {cmd=0,sym}.
//   st_escape: on read, sym==ESC -> push {0,ESC}, st_idle (literal escape);
//              else push {1,sym}, st_idle (command).
//  Latency: symbol read at edge n is visible at the queue head after edge n (next cycle).
//   Back-to-back: one symbol read per cycle while !RX_EMPTY_I and not full.
//  Queue: FWFT; DATA_REC_O/COMMAND_O = head entry, hold while !READ_I. READ_I when
//   RX_EMPTY_O=1 is ignored. Push+pop same cycle: LEVEL_O unchanged, order preserved.
//   Pointers are $clog2(DEPTH) bits and wrap naturally.
//  A lone ESC at stream end stays pending in st_escape indefinitely (unless timeout enabled).
// CONFIGURATION
//  RX_ESC_TIMEOUT_EN defined: counter cleared on entry to st_escape, incremented every cycle
//   in st_escape with no upstream read; reaching ESC_TIMEOUT-1 -> st_idle, ESC_TIMEOUT_O high
//   for one cycle, nothing pushed. A read in the same cycle as expiry wins (normal decode,
//   no pulse). Counter width $clog2(ESC_TIMEOUT).
//  Undefined: no counter; st_escape waits forever; ESC_TIMEOUT_O tied 0.
// STRUCTURE
//  Package rx_escape_pkg: state_t {st_idle, st_escape}; typedef struct packed {logic cmd;
//   logic [WIDTH-1:0] data;} entry type (parametrised via module-local typedef); default ESC.
//  Sub-module rx_escape_fifo: sync FWFT FIFO, WIDTH+1 bits x DEPTH, push/pop/level/empty/full;
//   top module holds FSM, upstream handshake and optional timeout counter.
// TESTING
//  1 Stream 8'h41,8'h42, TAP idle -> READ_O two strobes; LEVEL_O=2; head 8'h41, COMMAND_O=0.
//  2 Stream B1,05 -> one entry {cmd=1,05}; COMMAND_O=1, DATA_REC_O=05; READ_I -> RX_EMPTY_O=1.
//  3 Stream B1,B1,B1,07 -> entries {0,B1},{1,07} in order; LEVEL_O=2.
//  4 DEPTH=4, 6 data symbols, READ_I=0 -> READ_O stops after 4, LEVEL_O=4; one READ_I ->
//    next cycle READ_O=1, 5th symbol enters, order 1..6 preserved across pointer wrap.
//  5 Simultaneous push+pop at LEVEL_O=2 -> LEVEL_O stays 2; READ_I with queue empty -> no-op.
//  6 RX_ESC_TIMEOUT_EN, ESC_TIMEOUT=16: B1 then idle 16 cycles -> ESC_TIMEOUT_O one pulse,
//    st_idle; then 05 -> {cmd=0,05}. Reset asserted after B1 -> following 05 decodes as data.

Source files
------------

// File: rtl/rx_escape_pkg.sv
// rx_escape_pkg: shared types and defaults for the RX escape decoder.
//   state_t      decoder FSM states
//   ESC_DEFAULT  default escape symbol
package rx_escape_pkg;

    typedef enum logic {st_idle, st_escape} state_t;

    localparam logic [7:0] ESC_DEFAULT = 8'hB1;

endpackage

// File: rtl/rx_escape_fifo.sv
// rx_escape_fifo: synchronous first-word-fall-through FIFO, W bits x DEPTH entries.
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write strobe and data (ignored when full)
//   pop         read strobe (ignored when empty)
//   dout        head entry, zero while empty
//   level       occupancy; empty / full flags
module rx_escape_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap without explicit compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/rx_escape_decoder.sv
// rx_escape_decoder: strips ESC sequences from the UART-RX stream, tags commands,
// and queues decoded symbols for the debug TAP.
//   CLK_I, RST_NI   clock, asynchronous active-low reset
//   DATA_REC_I      UART-RX head symbol;  RX_EMPTY_I  UART-RX empty
//   READ_O          UART-RX pop strobe
//   READ_I          TAP pops queue head;  RX_EMPTY_O  queue empty
//   COMMAND_O       head is a command;    DATA_REC_O  head symbol
//   LEVEL_O         queue occupancy
//   ESC_TIMEOUT_O   pulse when a pending escape is abandoned
// Optional feature: define RX_ESC_TIMEOUT_EN to abandon an escape left pending
// for ESC_TIMEOUT cycles; otherwise it waits forever and ESC_TIMEOUT_O is 0.
module rx_escape_decoder
    import rx_escape_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] ESC         = WIDTH'(ESC_DEFAULT),
    parameter int               DEPTH       = 4,
    parameter int               ESC_TIMEOUT = 1024
) (
    input  logic                         CLK_I,
    input  logic                         RST_NI,
    input  logic [WIDTH-1:0]             DATA_REC_I,
    input  logic                         RX_EMPTY_I,
    output logic                         READ_O,
    input  logic                         READ_I,
    output logic                         RX_EMPTY_O,
    output logic                         COMMAND_O,
    output logic [WIDTH-1:0]             DATA_REC_O,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL_O,
    output logic                         ESC_TIMEOUT_O
);

    typedef struct packed {
        logic             cmd;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_t state;
    entry_t push_entry, head;
    logic   full, push, is_esc;

    // no fall-through: a full queue blocks upstream even if the TAP pops this cycle
    assign READ_O     = !RX_EMPTY_I && !full;
    assign is_esc     = DATA_REC_I == ESC;
    assign push       = READ_O && (state == st_escape || !is_esc);
    assign push_entry = {state == st_escape && !is_esc, DATA_REC_I};
    assign COMMAND_O  = head.cmd;
    assign DATA_REC_O = head.data;

    rx_escape_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK_I),
        .rst_n (RST_NI),
        .push  (push),
        .din   (push_entry),
        .pop   (READ_I),
        .dout  (head),
        .level (LEVEL_O),
        .empty (RX_EMPTY_O),
        .full  (full)
    );

`ifdef RX_ESC_TIMEOUT_EN
    localparam int CW = $clog2(ESC_TIMEOUT);

    logic [CW-1:0] cnt;

    // any upstream read clears the counter, which covers entry into st_escape;
    // a read in the expiry cycle takes priority over the timeout
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state         <= st_idle;
            cnt           <= '0;
            ESC_TIMEOUT_O <= 1'b0;
        end else begin
            ESC_TIMEOUT_O <= 1'b0;
            if (READ_O) begin
                state <= (state == st_idle && is_esc) ? st_escape : st_idle;
                cnt   <= '0;
            end else if (state == st_escape) begin
                if (cnt == CW'(ESC_TIMEOUT - 1)) begin
                    state         <= st_idle;
                    ESC_TIMEOUT_O <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
`else
    assign ESC_TIMEOUT_O = 1'b0;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) state <= st_idle;
        else if (READ_O) state <= (state == st_idle && is_esc) ? st_escape : st_idle;
    end
`endif

endmodule
